mac2b_seq: RTL

Sequential multiply-accumulate stage wrapped around the team's 2-bit combinational multiplier (x, y → 4-bit product z). It accepts a stream of 2-bit operand pairs over a valid/ready handshake and multiplies each pair with one internal instance of that multiplier. It sums N products into an accumulator and presents each dot-product result downstream over a second valid/ready handshake. It turns the purely combinational multiplier into a streaming datapath element.

---
 rtl/mac2b_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mac2b_seq.sv
// mac2b_seq: streaming multiply-accumulate stage built around the 2-bit
// combinational multiplier. Accepts N operand pairs over a valid/ready
// handshake, sums their products and hands the dot product downstream
// over a second valid/ready handshake.

// 2-bit x 2-bit combinational multiplier producing a 4-bit product.
module mac2b_mul (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] z
);

   logic [3:0] pp0;
   logic [3:0] pp1;

   // Sum of the two shifted partial products.
   always_comb begin
      pp0 = {2'b00, x & {2{y[0]}}};
      pp1 = {1'b0, x & {2{y[1]}}, 1'b0};
      z   = pp0 + pp1;
   end

endmodule

module mac2b_seq #(
   parameter int N     = 4,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       x,
   input  logic [1:0]       y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic {
      ACCUM,
      DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             ovf_r;
   logic             ovf_r_n;
   logic [ACC_W-1:0] acc_out_n;
   logic             ovf_n;
   logic             out_valid_n;
   logic [3:0]       z;
   logic [ACC_W:0]   sum;
   logic             fire;

   mac2b_mul u_mul (
      .x (x),
      .y (y),
      .z (z)
   );

   // Ready depends only on state and reset so it never combinationally
   // loops back through the upstream valid.
   assign in_ready = (state == ACCUM) && rst_n;
   assign fire     = in_valid && in_ready;

   // One extra bit on the adder exposes the carry used for the overflow flag.
   always_comb begin
      sum = {1'b0, acc} + {{(ACC_W - 3){1'b0}}, z};
   end

   // Next-state and next-register values; everything holds by default.
   always_comb begin
      state_n     = state;
      acc_n       = acc;
      cnt_n       = cnt;
      ovf_r_n     = ovf_r;
      acc_out_n   = acc_out;
      ovf_n       = ovf;
      out_valid_n = out_valid;
      case (state)
         ACCUM: begin
            if (fire) begin
               if (cnt == LAST) begin
                  acc_out_n   = sum[ACC_W-1:0];
                  ovf_n       = ovf_r | sum[ACC_W];
                  out_valid_n = 1'b1;
                  state_n     = DONE;
                  acc_n       = '0;
                  cnt_n       = '0;
                  ovf_r_n     = 1'b0;
               end else begin
                  acc_n   = sum[ACC_W-1:0];
                  ovf_r_n = ovf_r | sum[ACC_W];
                  cnt_n   = cnt + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               state_n     = ACCUM;
            end
         end
         default: begin
            state_n = ACCUM;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf_r     <= 1'b0;
         acc_out   <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         cnt       <= cnt_n;
         ovf_r     <= ovf_r_n;
         acc_out   <= acc_out_n;
         ovf       <= ovf_n;
         out_valid <= out_valid_n;
      end
   end

endmodule
